// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program/data loaders.
// Holds the loader FSM state encoding and the end-of-program marker.
package loader_pkg;

  typedef enum logic [2:0] {
    LOAD,
    MODE,
    WAIT_START,
    RUN,
    STEP_IDLE,
    STEP_DUMP,
    DONE
  } state_e;

  // The end marker doubles as the processor's halt opcode.
  localparam logic [31:0] END_MARKER    = 32'hFFFF_FFFF;
  localparam int          MODE_STEP_BIT = 0;

endpackage

// File: rtl/uart_program_loader_if.sv
// Signal bundle between the program loader and its surroundings
// (UART RX core, instruction memory write port, pipeline control, dump unit).
interface uart_program_loader_if #(
  parameter int N_BITS     = 8,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic [N_BITS-1:0]     i_rx_data;
  logic                  i_rx_done;
  logic                  i_halt;
  logic                  i_dump_busy;

  logic                  o_inst_wr_en;
  logic [ADDR_WIDTH-1:0] o_inst_addr;
  logic [INST_WIDTH-1:0] o_inst_data;
  logic                  o_run;
  logic                  o_step;
  logic                  o_dump_req;
  logic                  o_overflow;
  logic                  o_done;

  // Loader side.
  modport master (
    input  i_rx_data, i_rx_done, i_halt, i_dump_busy,
    output o_inst_wr_en, o_inst_addr, o_inst_data,
    output o_run, o_step, o_dump_req, o_overflow, o_done
  );

  // Environment side: UART, memory, processor and dump unit.
  modport slave (
    output i_rx_data, i_rx_done, i_halt, i_dump_busy,
    input  o_inst_wr_en, o_inst_addr, o_inst_data,
    input  o_run, o_step, o_dump_req, o_overflow, o_done
  );

endinterface

// File: rtl/word_assembler.sv
// Packs consecutive bytes into one word, first byte in the least significant
// position, and flags the cycle in which the last byte completes the word.
module word_assembler #(
  parameter int N_BITS     = 8,
  parameter int INST_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [N_BITS-1:0]     i_data,
  output logic [INST_WIDTH-1:0] o_word,
  output logic                  o_word_valid
);

  localparam int N_BYTES = INST_WIDTH / N_BITS;
  localparam int CNT_W   = $clog2(N_BYTES);
  localparam int SHIFT_W = INST_WIDTH - N_BITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               word_valid;

  // Only the earlier bytes are stored; the final byte is merged on the fly.
  assign o_word       = {i_data, shift_q};
  assign o_word_valid = word_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_valid = 1'b0;
    if (i_en && i_valid) begin
      shift_d = {i_data, shift_q[SHIFT_W-1:N_BITS]};
      if (byte_cnt_q == LAST_CNT) begin
        byte_cnt_d = '0;
        word_valid = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program from UART bytes into instruction memory, then runs the
// processor continuously or one cycle per received byte, requesting dumps.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  uart_program_loader_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INST_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  run_q, run_d;
  logic                  step_q, step_d;
  logic                  dump_q, dump_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;

  logic [INST_WIDTH-1:0] word;
  logic                  word_valid;
  logic                  rx_bit0;

  assign rx_bit0 = bus.i_rx_data[MODE_STEP_BIT];

  word_assembler #(
    .N_BITS    (N_BITS),
    .INST_WIDTH(INST_WIDTH)
  ) u_word_assembler (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (state_q == LOAD),
    .i_valid     (bus.i_rx_done),
    .i_data      (bus.i_rx_data),
    .o_word      (word),
    .o_word_valid(word_valid)
  );

  always_comb begin
    state_d    = state_q;
    // Address advances in the cycle after the write strobe.
    addr_d     = wr_en_q ? addr_q + 1'b1 : addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    step_d     = 1'b0;
    dump_d     = 1'b0;
    overflow_d = overflow_q;

    unique case (state_q)
      LOAD: begin
        if (word_valid) begin
          wr_en_d = 1'b1;
          data_d  = word;
          if (word == END_MARKER) begin
            state_d = MODE;
          end else if (addr_q == LAST_ADDR) begin
            overflow_d = 1'b1;
            state_d    = MODE;
          end
        end
      end
      MODE: begin
        if (bus.i_rx_done) begin
          if (rx_bit0) begin
            state_d = STEP_IDLE;
            dump_d  = 1'b1;
          end else begin
            state_d = WAIT_START;
          end
        end
      end
      WAIT_START: begin
        if (bus.i_rx_done) state_d = RUN;
      end
      RUN: begin
        if (bus.i_halt) begin
          state_d = DONE;
          dump_d  = 1'b1;
        end
      end
      STEP_IDLE: begin
        if (bus.i_rx_done && rx_bit0 && !bus.i_dump_busy && !bus.i_halt) begin
          step_d  = 1'b1;
          state_d = STEP_DUMP;
        end
      end
      STEP_DUMP: begin
        // First cycle: o_step is out, request the dump. Second cycle: the dump
        // request is out and the processor has reported any halt.
        if (step_q) begin
          dump_d = 1'b1;
        end else begin
          state_d = bus.i_halt ? DONE : STEP_IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = LOAD;
    endcase

    run_d  = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= LOAD;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      run_q      <= 1'b0;
      step_q     <= 1'b0;
      dump_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      run_q      <= run_d;
      step_q     <= step_d;
      dump_q     <= dump_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_inst_wr_en = wr_en_q;
  assign bus.o_inst_addr  = addr_q;
  assign bus.o_inst_data  = data_q;
  assign bus.o_run        = run_q;
  assign bus.o_step       = step_q;
  assign bus.o_dump_req   = dump_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader with a small (4-word) memory,
// random byte streams and a queue-based reference model.
module tb_uart_program_loader;

  localparam int NB    = 8;
  localparam int IW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] MARK = 32'hFFFF_FFFF;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_program_loader_if #(.N_BITS(NB), .INST_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  uart_program_loader #(.N_BITS(NB), .INST_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  int  last_acc = 0;
  wr_t wr_log[$];
  int  step_log[$];
  int  dump_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are sampled mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_inst_wr_en) wr_log.push_back('{cyc, bus.o_inst_addr, bus.o_inst_data});
      if (bus.o_step)       step_log.push_back(cyc);
      if (bus.o_dump_req)   dump_log.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    step_log.delete();
    dump_log.delete();
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.i_rx_data    = '0;
    bus.i_rx_done    = 1'b0;
    bus.i_halt       = 1'b0;
    bus.i_dump_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 clear_logs();
  endtask

  // One-cycle rx_done pulse; returns 1+idle cycles after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int idle);
    @(posedge clk);
    #1;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    last_acc      = cyc;
    @(posedge clk);
    #1;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'($urandom);
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int idle);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], idle);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
    if (w == MARK) w[3] = 1'b0;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_rx_data = '0; bus.i_rx_done = 1'b0; bus.i_halt = 1'b0; bus.i_dump_busy = 1'b0;
    #2;
    n_checks += 8;
    if (bus.o_inst_wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got=%b exp=0", bus.o_inst_wr_en); end
    if (bus.o_inst_addr !== '0)    begin n_errors++; $display("FAIL reset_addr got=%0d exp=0", bus.o_inst_addr); end
    if (bus.o_inst_data !== '0)    begin n_errors++; $display("FAIL reset_data got=%h exp=0", bus.o_inst_data); end
    if (bus.o_run !== 1'b0)        begin n_errors++; $display("FAIL reset_run got=%b exp=0", bus.o_run); end
    if (bus.o_step !== 1'b0)       begin n_errors++; $display("FAIL reset_step got=%b exp=0", bus.o_step); end
    if (bus.o_dump_req !== 1'b0)   begin n_errors++; $display("FAIL reset_dump got=%b exp=0", bus.o_dump_req); end
    if (bus.o_overflow !== 1'b0)   begin n_errors++; $display("FAIL reset_overflow got=%b exp=0", bus.o_overflow); end
    if (bus.o_done !== 1'b0)       begin n_errors++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
    do_reset();
  endtask

  task automatic test_load_run();
    int acc4, accm;
    do_reset();
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h20, 0);
    acc4 = last_acc;
    send_word(MARK, 0);
    accm = last_acc;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wr_log.size() != 2) begin
      n_errors++; $display("FAIL load_write_count got=%0d exp=2", wr_log.size());
    end else begin
      n_checks += 4;
      if (wr_log[0].addr !== 0 || wr_log[0].data !== 32'h2010_0013) begin
        n_errors++; $display("FAIL load_word0 got=%0d:%h exp=0:20100013", wr_log[0].addr, wr_log[0].data);
      end
      if (wr_log[0].cyc != acc4 + 1) begin
        n_errors++; $display("FAIL load_word0_timing got=%0d exp=%0d", wr_log[0].cyc, acc4 + 1);
      end
      if (wr_log[1].addr !== 1 || wr_log[1].data !== MARK) begin
        n_errors++; $display("FAIL load_marker got=%0d:%h exp=1:ffffffff", wr_log[1].addr, wr_log[1].data);
      end
      if (wr_log[1].cyc != accm + 1) begin
        n_errors++; $display("FAIL load_marker_timing got=%0d exp=%0d", wr_log[1].cyc, accm + 1);
      end
    end
    send_byte(8'h00, 0);
    n_checks++;
    if (bus.o_run !== 1'b0) begin n_errors++; $display("FAIL run_before_start got=%b exp=0", bus.o_run); end
    send_byte(8'h00, 0);
    n_checks++;
    if (bus.o_run !== 1'b1) begin n_errors++; $display("FAIL run_after_start got=%b exp=1", bus.o_run); end
    repeat (3) @(posedge clk);
    #1 bus.i_halt = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 3;
    if (bus.o_run !== 1'b0)      begin n_errors++; $display("FAIL halt_run got=%b exp=0", bus.o_run); end
    if (bus.o_dump_req !== 1'b1) begin n_errors++; $display("FAIL halt_dump got=%b exp=1", bus.o_dump_req); end
    if (bus.o_done !== 1'b1)     begin n_errors++; $display("FAIL halt_done got=%b exp=1", bus.o_done); end
    bus.i_halt = 1'b0;
    send_byte(8'h01, 2);
    send_byte(8'h00, 2);
    n_checks += 3;
    if (dump_log.size() != 1) begin n_errors++; $display("FAIL run_dump_count got=%0d exp=1", dump_log.size()); end
    if (bus.o_done !== 1'b1)  begin n_errors++; $display("FAIL done_held got=%b exp=1", bus.o_done); end
    if (step_log.size() != 0 || bus.o_run !== 1'b0) begin
      n_errors++; $display("FAIL done_inert got steps=%0d run=%b exp steps=0 run=0", step_log.size(), bus.o_run);
    end
  endtask

  task automatic test_random_load(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [31:0] words[$];
      wr_t         expq[$];
      int          nw, n_send;
      logic        ovf;
      do_reset();
      nw = (it == 0) ? DEPTH - 1 : int'($urandom_range(0, DEPTH + 1));
      for (int i = 0; i < nw; i++) words.push_back(rand_word());
      words.push_back(MARK);
      ovf = 1'b0; n_send = 0;
      foreach (words[i]) begin
        expq.push_back('{0, AW'(i), words[i]});
        n_send = i + 1;
        if (words[i] == MARK) break;
        if (i == DEPTH - 1) begin ovf = 1'b1; break; end
      end
      for (int i = 0; i < n_send; i++) send_word(words[i], int'($urandom_range(0, 2)));
      repeat (3) @(posedge clk);
      #1;
      n_checks += 2;
      if (wr_log.size() != expq.size()) begin
        n_errors++; $display("FAIL rand_write_count it=%0d got=%0d exp=%0d", it, wr_log.size(), expq.size());
      end
      if (bus.o_overflow !== ovf) begin
        n_errors++; $display("FAIL rand_overflow it=%0d got=%b exp=%b", it, bus.o_overflow, ovf);
      end
      for (int i = 0; i < expq.size() && i < wr_log.size(); i++) begin
        n_checks++;
        if (wr_log[i].addr !== expq[i].addr || wr_log[i].data !== expq[i].data) begin
          n_errors++;
          $display("FAIL rand_write it=%0d idx=%0d got=%0d:%h exp=%0d:%h", it, i,
                   wr_log[i].addr, wr_log[i].data, expq[i].addr, expq[i].data);
        end
      end
      send_byte({7'($urandom), 1'b0}, 0);
      send_byte(8'($urandom), 0);
      n_checks++;
      if (bus.o_run !== 1'b1) begin n_errors++; $display("FAIL rand_run it=%0d got=%b exp=1", it, bus.o_run); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w[4] = '{32'hFFFF_FF00, 32'h00FF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF};
    do_reset();
    foreach (w[i]) send_word(w[i], 0);
    // Fifth word: its first byte lands in MODE (continuous), its second starts RUN.
    send_word(32'h0000_0102, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks += 3;
    if (wr_log.size() != 4)     begin n_errors++; $display("FAIL ovf_write_count got=%0d exp=4", wr_log.size()); end
    if (bus.o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got=%b exp=1", bus.o_overflow); end
    if (bus.o_run !== 1'b1)     begin n_errors++; $display("FAIL ovf_mode_then_run got=%b exp=1", bus.o_run); end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i].addr !== AW'(i) || wr_log[i].data !== w[i]) begin
        n_errors++; $display("FAIL ovf_write idx=%0d got=%0d:%h exp=%0d:%h", i, wr_log[i].addr, wr_log[i].data, i, w[i]);
      end
    end
  endtask

  task automatic test_step(input int nbytes);
    int exp_step[$];
    do_reset();
    send_word(MARK, 0);
    send_byte({7'($urandom), 1'b1}, 0);
    n_checks++;
    if (bus.o_dump_req !== 1'b1) begin n_errors++; $display("FAIL step_initial_dump got=%b exp=1", bus.o_dump_req); end
    repeat (2) @(posedge clk);
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] b;
      logic       busy;
      b    = (i == 0 || i == 2) ? 8'h01 : (i == 1) ? 8'h00 : 8'($urandom);
      busy = (i == 0) ? 1'b1 : (i < 3) ? 1'b0 : ($urandom % 4 == 0);
      bus.i_dump_busy = busy;
      send_byte(b, 0);
      bus.i_dump_busy = 1'b0;
      if (b[0] && !busy) exp_step.push_back(last_acc + 1);
      repeat (2) begin @(posedge clk); #1; end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks += 2;
    if (step_log.size() != exp_step.size()) begin
      n_errors++; $display("FAIL step_count got=%0d exp=%0d", step_log.size(), exp_step.size());
    end
    if (dump_log.size() != exp_step.size() + 1) begin
      n_errors++; $display("FAIL step_dump_count got=%0d exp=%0d", dump_log.size(), exp_step.size() + 1);
    end
    for (int i = 0; i < exp_step.size() && i < step_log.size(); i++) begin
      n_checks++;
      if (step_log[i] != exp_step[i]) begin
        n_errors++; $display("FAIL step_timing idx=%0d got=%0d exp=%0d", i, step_log[i], exp_step[i]);
      end
    end
    for (int i = 0; i < exp_step.size() && i + 1 < dump_log.size(); i++) begin
      n_checks++;
      if (dump_log[i+1] != exp_step[i] + 1) begin
        n_errors++; $display("FAIL step_dump_timing idx=%0d got=%0d exp=%0d", i, dump_log[i+1], exp_step[i] + 1);
      end
    end
  endtask

  task automatic test_halt_step();
    do_reset();
    send_word(MARK, 0);
    send_byte(8'h01, 2);
    send_byte(8'h01, 2);
    send_byte(8'h01, 0);
    n_checks++;
    if (bus.o_step !== 1'b1) begin n_errors++; $display("FAIL hstep_step got=%b exp=1", bus.o_step); end
    @(posedge clk);
    #1 bus.i_halt = 1'b1;
    n_checks++;
    if (bus.o_dump_req !== 1'b1) begin n_errors++; $display("FAIL hstep_dump got=%b exp=1", bus.o_dump_req); end
    @(posedge clk);
    #1 bus.i_halt = 1'b0;
    n_checks++;
    if (bus.o_done !== 1'b1) begin n_errors++; $display("FAIL hstep_done got=%b exp=1", bus.o_done); end
    repeat (3) send_byte(8'h01, 2);
    n_checks += 3;
    if (step_log.size() != 2) begin n_errors++; $display("FAIL hstep_step_count got=%0d exp=2", step_log.size()); end
    if (dump_log.size() != 3) begin n_errors++; $display("FAIL hstep_dump_count got=%0d exp=3", dump_log.size()); end
    if (bus.o_done !== 1'b1)  begin n_errors++; $display("FAIL hstep_done_held got=%b exp=1", bus.o_done); end
  endtask

  task automatic test_halt_with_byte();
    do_reset();
    send_word(MARK, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 2);
    @(posedge clk);
    #1;
    bus.i_rx_data = 8'h01; bus.i_rx_done = 1'b1; bus.i_halt = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_done = 1'b0;
    n_checks += 3;
    if (bus.o_done !== 1'b1)     begin n_errors++; $display("FAIL hbyte_done got=%b exp=1", bus.o_done); end
    if (bus.o_run !== 1'b0)      begin n_errors++; $display("FAIL hbyte_run got=%b exp=0", bus.o_run); end
    if (bus.o_dump_req !== 1'b1) begin n_errors++; $display("FAIL hbyte_dump got=%b exp=1", bus.o_dump_req); end
    repeat (3) @(posedge clk);
    #1 bus.i_halt = 1'b0;
    n_checks++;
    if (dump_log.size() != 1 || step_log.size() != 0) begin
      n_errors++; $display("FAIL hbyte_single_dump got dumps=%0d steps=%0d exp dumps=1 steps=0", dump_log.size(), step_log.size());
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus.o_inst_addr !== '0 || bus.o_inst_wr_en !== 1'b0) begin
      n_errors++; $display("FAIL midrst_addr got=%0d wr=%b exp=0 wr=0", bus.o_inst_addr, bus.o_inst_wr_en);
    end
    do_reset();
    send_word(32'hDEAD_BEEF, 0);
    send_word(MARK, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wr_log.size() != 2) begin
      n_errors++; $display("FAIL midrst_count got=%0d exp=2", wr_log.size());
    end else begin
      n_checks += 2;
      if (wr_log[0].addr !== 0 || wr_log[0].data !== 32'hDEAD_BEEF) begin
        n_errors++; $display("FAIL midrst_word got=%0d:%h exp=0:deadbeef", wr_log[0].addr, wr_log[0].data);
      end
      if (wr_log[1].addr !== 1 || wr_log[1].data !== MARK) begin
        n_errors++; $display("FAIL midrst_marker got=%0d:%h exp=1:ffffffff", wr_log[1].addr, wr_log[1].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_random_load(12);
    test_overflow();
    test_step(14);
    test_halt_step();
    test_halt_with_byte();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Control-side counterpart of the host program sender: consumes bytes from the UART receiver, assembles 32-bit instructions (4 bytes, LSB first), and writes them into instruction memory until the end marker 0xFFFFFFFF. It then takes an execution-mode byte and drives the processor in continuous or step-by-step mode. It also requests a debug dump after each step, and at halt. It sits in `top` between the UART RX core, the instruction memory write port, the pipeline enable, and the debug/TX dump unit.

## Interface
Parameters:
- N_BITS, 8, UART data width.
- INST_WIDTH, 32, instruction width; must equal 4*N_BITS.
- ADDR_WIDTH, 10, instruction memory word-address width.

Ports:
- i_clk  in  1  system clock. One clock domain; all logic on its rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_rx_data  in  N_BITS  received byte; valid only in the cycle i_rx_done is high.
- i_rx_done  in  1  single-cycle pulse from the UART RX core: byte available.
- i_halt  in  1  level from the processor: halt instruction has retired.
- i_dump_busy  in  1  level from the dump unit: debug transmission in progress.
- o_inst_wr_en  out  1  instruction memory write strobe, one cycle per word.
- o_inst_addr  out  ADDR_WIDTH  word address for the write.
- o_inst_data  out  INST_WIDTH  assembled instruction.
- o_run  out  1  level: processor clock-enable in continuous mode.
- o_step  out  1  single-cycle pulse: advance the processor one cycle.
- o_dump_req  out  1  single-cycle pulse: start a debug dump.
- o_overflow  out  1  sticky: program exceeded memory depth.
- o_done  out  1  level: execution finished; held until reset.

## Operation
States:
- LOAD
  - Each i_rx_done shifts the byte into word position byte_cnt; byte 0 goes to bits [7:0].
  - byte_cnt is 2 bits and wraps 3 -> 0.
  - On the 4th byte: write the word and increment the address.
  - If the word is 0xFFFFFFFF, the marker is also written, because it is the halt opcode. Then go to MODE.
  - If the write was at address 2^ADDR_WIDTH-1 and the word is not the marker: set o_overflow and go to MODE.
- MODE
  - Next byte selects the mode by bit0: 0 = continuous -> WAIT_START; 1 = step -> STEP_IDLE, issuing one o_dump_req (initial state).
  - Bits [7:1] are ignored.
- WAIT_START: next byte of any value -> RUN.
- RUN
  - o_run=1.
  - When i_halt goes high: drop o_run, pulse o_dump_req, go to DONE.
  - Received bytes are ignored.
- STEP_IDLE
  - A byte with bit0=1, while i_dump_busy=0 and i_halt=0: pulse o_step, go to STEP_DUMP.
  - Bytes with bit0=0 are ignored.
  - Bytes arriving while i_dump_busy=1 are dropped.
- STEP_DUMP
  - Pulse o_dump_req in the cycle after o_step.
  - If i_halt is high in that cycle -> DONE, otherwise -> STEP_IDLE.
- DONE: o_done=1; all bytes ignored; exit only by reset.

Boundary rules:
- i_rx_done and i_halt in the same cycle in RUN: halt wins, the byte is dropped.
- Reset mid-load: partial word discarded, address back to 0, memory contents untouched.
- Marker detection uses the full assembled word only. A 0xFF byte alone does nothing.

## Timing
- Reset values: o_inst_wr_en=0, o_inst_addr=0, o_inst_data=0, o_run=0, o_step=0, o_dump_req=0, o_overflow=0, o_done=0; state LOAD; byte_cnt=0.
- All outputs are registered.
- Word write: o_inst_wr_en is high in the cycle after the i_rx_done of the 4th byte. o_inst_addr and o_inst_data are stable in that cycle; the address increments the following cycle.
- Mode/start byte: o_run rises 1 cycle after the start-byte i_rx_done.
- Halt: o_run falls and o_dump_req pulses 1 cycle after i_halt rises; o_done rises in the same cycle.
- Step: o_step 1 cycle after the accepted i_rx_done; o_dump_req 1 cycle after o_step. Exactly one processor cycle per accepted byte.
- Consecutive i_rx_done pulses are at least 2 cycles apart; no back-pressure toward the UART.

## Structure
- Shared package `loader_pkg`:
  - state enum LOAD, MODE, WAIT_START, RUN, STEP_IDLE, STEP_DUMP, DONE;
  - constants END_MARKER=32'hFFFF_FFFF, MODE_STEP_BIT=0.
- Sub-module `word_assembler`: byte_cnt, shift register, and the word-valid pulse. Reused by the data-memory loader.
- The remaining FSM lives in uart_program_loader.

## Test plan
- Load and run:
  - Stimulus: bytes 0x13,0x00,0x10,0x20 then FF,FF,FF,FF, mode 0x00, start 0x00.
  - Response: write addr0=0x20100013, write addr1=0xFFFFFFFF; o_run=1; on i_halt, one o_dump_req and o_done=1.
- Step mode:
  - Stimulus: marker, mode 0x01, one o_dump_req, then three 0x01 bytes.
  - Response: three o_step pulses, each followed next cycle by o_dump_req; 0x00 bytes produce nothing.
- Halt during step:
  - Stimulus: i_halt raised in the cycle after the 2nd o_step.
  - Response: dump, then o_done=1; further 0x01 bytes produce no o_step.
- Overflow:
  - Stimulus: ADDR_WIDTH=2; five non-marker words.
  - Response: four writes at addr 0..3; o_overflow=1; FSM in MODE; 5th word not written.
- Reset mid-load:
  - Stimulus: assert i_reset after 2 bytes of word 1; release; then a full word 0xDEADBEEF.
  - Response: written at addr0 with no byte misalignment.
- Busy drop:
  - Stimulus: a step byte while i_dump_busy=1.
  - Response: no o_step.
